// File: rtl/blink_rate_meter.sv
// ============================================================================
// Module  : blink_rate_meter
// Brief   : Synchronises a slow square wave, measures its half-period and classifies
//           the result against four nominal blink rates. It also flags a stalled input.
//           Optional glitch filter: define BLINK_RATE_METER_GLITCH_FILTER_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module blink_rate_meter #(
  parameter int unsigned RATE1         = 12500000,
  parameter int unsigned RATE2         = 6250000,
  parameter int unsigned RATE3         = 3125000,
  parameter int unsigned RATE4         = 2500000,
  parameter int unsigned TOL           = 1000,
  parameter int unsigned TIMEOUT       = 15000000,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Sig,
  output logic [23:0] o_Half_Period,
  output logic        o_Valid,
  output logic [2:0]  o_Rate_Code,
  output logic        o_Timeout
);

  localparam logic [0:0]  c_IDLE    = 1'b0;
  localparam logic [0:0]  c_MEASURE = 1'b1;

  localparam logic [23:0] c_RATE1   = 24'(RATE1);
  localparam logic [23:0] c_RATE2   = 24'(RATE2);
  localparam logic [23:0] c_RATE3   = 24'(RATE3);
  localparam logic [23:0] c_RATE4   = 24'(RATE4);
  localparam logic [24:0] c_TOL     = 25'(TOL);
  localparam logic [23:0] c_TO_LAST = 24'(TIMEOUT - 1);

  generate
    if ((TIMEOUT < 2) || (TIMEOUT > 24'hFFFFFF) || (FILTER_CYCLES < 1)) begin : g_bad_param
      $error("blink_rate_meter: TIMEOUT or FILTER_CYCLES out of range");
    end
  endgenerate

  logic        r_sync1;
  logic        r_sync2;
  logic        r_level;
  logic        w_edge;

  logic [0:0]  r_state;
  logic [23:0] r_count;
  logic [23:0] w_meas;
  logic [2:0]  w_code;

  logic [23:0] r_half;
  logic        r_valid;
  logic [2:0]  r_code;
  logic        r_timeout;

  // 25-bit signed difference keeps |meas - rate| exact over the full 24-bit range.
  function automatic logic in_tol(input logic [23:0] meas, input logic [23:0] rate);
    logic signed [24:0] diff;
    logic        [24:0] mag;
    diff = $signed({1'b0, meas}) - $signed({1'b0, rate});
    mag  = diff[24] ? 25'(-diff) : 25'(diff);
    return (mag <= c_TOL);
  endfunction

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_Sig;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BLINK_RATE_METER_GLITCH_FILTER_EN
  localparam int                  c_FILT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILTER_CYCLES);

  logic [c_FILT_W-1:0] r_filt_cnt;
  logic                w_differ;

  assign w_differ = (r_sync2 != r_level);
  assign w_edge   = w_differ && (r_filt_cnt == c_FILT_LAST);

  // Restarts on any return to the accepted level, so short pulses never get through.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_filt_cnt <= '0;
    end else if (!w_differ || w_edge) begin
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end
`else
  assign w_edge = (r_sync2 != r_level);
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_level <= 1'b0;
    end else if (w_edge) begin
      r_level <= r_sync2;
    end
  end

  // The cycle carrying the edge is part of the interval, hence the +1.
  assign w_meas = r_count + 24'd1;

  always_comb begin
    w_code = 3'd0;
    if (in_tol(w_meas, c_RATE1)) begin
      w_code = 3'd1;
    end else if (in_tol(w_meas, c_RATE2)) begin
      w_code = 3'd2;
    end else if (in_tol(w_meas, c_RATE3)) begin
      w_code = 3'd3;
    end else if (in_tol(w_meas, c_RATE4)) begin
      w_code = 3'd4;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state   <= c_IDLE;
      r_count   <= '0;
      r_half    <= '0;
      r_valid   <= 1'b0;
      r_code    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == c_IDLE) begin
        r_count <= '0;
        if (w_edge) begin
          r_state   <= c_MEASURE;
          r_timeout <= 1'b0;
        end
      end else begin
        // An edge on the last counting cycle takes priority over the timeout.
        if (w_edge) begin
          r_half  <= w_meas;
          r_code  <= w_code;
          r_valid <= 1'b1;
          r_count <= '0;
        end else if (r_count == c_TO_LAST) begin
          r_state   <= c_IDLE;
          r_timeout <= 1'b1;
          r_code    <= '0;
          r_count   <= '0;
        end else if (r_count != 24'hFFFFFF) begin
          r_count <= r_count + 24'd1;
        end
      end
    end
  end

  assign o_Half_Period = r_half;
  assign o_Valid       = r_valid;
  assign o_Rate_Code   = r_code;
  assign o_Timeout     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_blink_rate_meter.sv
// ============================================================================
// Module  : tb_blink_rate_meter
// Brief   : Scoreboard bench for blink_rate_meter with small sim rates.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_blink_rate_meter;

`ifdef BLINK_RATE_METER_GLITCH_FILTER_EN
  localparam int LAT           = 3 + 4;
  localparam int GLITCH_VALIDS = 0;
`else
  localparam int LAT           = 3;
  localparam int GLITCH_VALIDS = 2;
`endif

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Sig = 1'b0;
  logic [23:0] o_Half_Period;
  logic        o_Valid;
  logic [2:0]  o_Rate_Code;
  logic        o_Timeout;

  blink_rate_meter #(
    .RATE1(10), .RATE2(20), .RATE3(40), .RATE4(50),
    .TOL(1), .TIMEOUT(60), .FILTER_CYCLES(4)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Sig        (i_Sig),
    .o_Half_Period(o_Half_Period),
    .o_Valid      (o_Valid),
    .o_Rate_Code  (o_Rate_Code),
    .o_Timeout    (o_Timeout)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [23:0] half;
    logic [2:0]  code;
  } exp_t;

  exp_t sb[$];
  int   n_pass   = 0;
  int   n_total  = 0;
  int   n_valid  = 0;
  int   cyc      = 0;
  int   last_tog = 0;

  always @(posedge i_Clk) cyc++;

  function automatic logic [2:0] model_code(input int m);
    if (m >= 9  && m <= 11) return 3'd1;
    if (m >= 19 && m <= 21) return 3'd2;
    if (m >= 39 && m <= 41) return 3'd3;
    if (m >= 49 && m <= 51) return 3'd4;
    return 3'd0;
  endfunction

  // Scoreboard consumer: every o_Valid pulse must match the oldest expectation.
  always @(negedge i_Clk) begin
    exp_t e;
    if (o_Valid === 1'b1) begin
      n_valid++;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_valid: got half=%0d code=%0d, required no valid",
                 o_Half_Period, o_Rate_Code);
      end else begin
        e = sb.pop_front();
        if (o_Half_Period !== e.half || o_Rate_Code !== e.code)
          $display("FAIL measurement: got half=%0d code=%0d, required half=%0d code=%0d",
                   o_Half_Period, o_Rate_Code, e.half, e.code);
        else
          n_pass++;
      end
    end
  end

  task automatic toggle(input bit expect_valid);
    exp_t e;
    int   m;
    m = cyc - last_tog;
    if (expect_valid) begin
      e.half = 24'(m);
      e.code = model_code(m);
      sb.push_back(e);
    end
    i_Sig    = ~i_Sig;
    last_tog = cyc;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic apply_reset;
    i_Sig   = 1'b0;
    i_Reset = 1'b1;
    wait_cycles(3);
    i_Reset = 1'b0;
    wait_cycles(3);
  endtask

  task automatic check_outputs_zero(input string tag);
    n_total++;
    if (o_Half_Period !== 24'd0 || o_Valid !== 1'b0 || o_Rate_Code !== 3'd0 || o_Timeout !== 1'b0)
      $display("FAIL %s: got half=%0d valid=%b code=%0d timeout=%b, required all 0",
               tag, o_Half_Period, o_Valid, o_Rate_Code, o_Timeout);
    else
      n_pass++;
  endtask

  task automatic test_reset;
    i_Sig   = 1'b0;
    i_Reset = 1'b1;
    wait_cycles(3);
    check_outputs_zero("reset_state");
    i_Reset = 1'b0;
    wait_cycles(3);
    check_outputs_zero("after_reset_idle");
  endtask

  task automatic test_steady_rate;
    int  n0;
    logic exp_v;
    apply_reset();
    toggle(1'b0);
    n0 = n_valid;
    wait_cycles(10);
    n_total++;
    if (n_valid !== n0) $display("FAIL first_edge_arms: got %0d valids, required 0", n_valid - n0);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      toggle(1'b1);
      for (int j = 1; j <= LAT; j++) begin
        @(negedge i_Clk);
        exp_v = (j == LAT);
        n_total++;
        if (o_Valid !== exp_v)
          $display("FAIL valid_latency: cycle %0d got valid=%b, required %b", j, o_Valid, exp_v);
        else
          n_pass++;
      end
      wait_cycles(10 - LAT);
    end
    wait_cycles(LAT + 2);
  endtask

  task automatic test_rates;
    int halves[4] = '{11, 12, 49, 52};
    apply_reset();
    toggle(1'b0);
    foreach (halves[i]) begin
      wait_cycles(halves[i]);
      toggle(1'b1);
    end
    wait_cycles(LAT + 2);
  endtask

  task automatic test_timeout;
    int n0;
    apply_reset();
    toggle(1'b0);
    wait_cycles(10);
    toggle(1'b1);
    wait_cycles(LAT + 59);
    n_total++;
    if (o_Timeout !== 1'b0) $display("FAIL timeout_early: got %b, required 0", o_Timeout);
    else n_pass++;
    @(negedge i_Clk);
    n_total++;
    if (o_Timeout !== 1'b1 || o_Rate_Code !== 3'd0 || o_Half_Period !== 24'd10)
      $display("FAIL timeout_state: got timeout=%b code=%0d half=%0d, required 1 0 10",
               o_Timeout, o_Rate_Code, o_Half_Period);
    else
      n_pass++;
    toggle(1'b0);
    n0 = n_valid;
    wait_cycles(LAT - 1);
    n_total++;
    if (o_Timeout !== 1'b1) $display("FAIL timeout_held: got %b, required 1", o_Timeout);
    else n_pass++;
    @(negedge i_Clk);
    n_total++;
    if (o_Timeout !== 1'b0) $display("FAIL timeout_clear: got %b, required 0", o_Timeout);
    else n_pass++;
    wait_cycles(10 - LAT);
    n_total++;
    if (n_valid !== n0) $display("FAIL rearm_no_valid: got %0d valids, required 0", n_valid - n0);
    else n_pass++;
    toggle(1'b1);
    wait_cycles(LAT + 2);
  endtask

  task automatic test_timeout_boundary;
    apply_reset();
    toggle(1'b0);
    wait_cycles(60);
    toggle(1'b1);
    wait_cycles(LAT + 1);
    n_total++;
    if (o_Timeout !== 1'b0) $display("FAIL edge_wins_timeout: got %b, required 0", o_Timeout);
    else n_pass++;
    wait_cycles(61 - (LAT + 1));
    toggle(1'b0);
    wait_cycles(LAT - 1);
    n_total++;
    if (o_Timeout !== 1'b1) $display("FAIL timeout_61: got %b, required 1", o_Timeout);
    else n_pass++;
    @(negedge i_Clk);
    n_total++;
    if (o_Timeout !== 1'b0) $display("FAIL rearm_after_61: got %b, required 0", o_Timeout);
    else n_pass++;
    wait_cycles(20 - LAT);
    toggle(1'b1);
    wait_cycles(LAT + 2);
  endtask

  task automatic test_reset_mid;
    int n0;
    int w;
    apply_reset();
    toggle(1'b0);
    wait_cycles(20);
    toggle(1'b1);
    w = (LAT + 1 > 5) ? LAT + 1 : 5;
    wait_cycles(w);
    i_Reset = 1'b1;
    @(negedge i_Clk);
    i_Reset = 1'b0;
    check_outputs_zero("mid_reset");
    wait_cycles(20 - w);
    toggle(1'b0);
    n0 = n_valid;
    wait_cycles(20);
    n_total++;
    if (n_valid !== n0) $display("FAIL post_reset_arm: got %0d valids, required 0", n_valid - n0);
    else n_pass++;
    toggle(1'b1);
    wait_cycles(LAT + 2);
  endtask

  task automatic test_glitch;
    int n0;
    apply_reset();
    toggle(1'b0);
    wait_cycles(20);
    toggle(1'b1);
    wait_cycles(8);
    n0 = n_valid;
`ifdef BLINK_RATE_METER_GLITCH_FILTER_EN
    i_Sig = 1'b1;
    wait_cycles(2);
    i_Sig = 1'b0;
`else
    toggle(1'b1);
    wait_cycles(2);
    toggle(1'b1);
`endif
    wait_cycles(10);
    n_total++;
    if (n_valid - n0 !== GLITCH_VALIDS)
      $display("FAIL glitch_valids: got %0d, required %0d", n_valid - n0, GLITCH_VALIDS);
    else
      n_pass++;
    toggle(1'b1);
    wait_cycles(LAT + 2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_steady_rate();
    test_rates();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    test_glitch();
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drained: got %0d pending, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
